// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard mode timings, the per-axis timing struct and
// the scan-region encoding used by the axis counters.
package vga_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

    // Pipeline payload that travels alongside the colour towards the pins.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } pin_ctrl_t;

    localparam axis_timing_t VGA640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t VGA640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam axis_timing_t VGA800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam axis_timing_t VGA800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

    function automatic int axis_total(axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// Frame-buffer read port: the scan engine issues strobe/address, memory returns data.
interface vga_scan_engine_if #(
    parameter int ADDR_W = 17,
    parameter int RGB_W  = 3
) ();
    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    logic [RGB_W-1:0]  fb_data;

    modport master (output fb_rd, output fb_addr, input fb_data);
    modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter with wrap, plus decode of active/porch/sync region.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int  ACT_LEN  = 640,
    parameter int  FP_LEN   = 16,
    parameter int  SYNC_LEN = 96,
    parameter int  BP_LEN   = 48,
    localparam int TOTAL    = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN,
    localparam int CW       = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output region_e       region_o
);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FP_START   = CW'(ACT_LEN);
    localparam logic [CW-1:0] SYNC_START = CW'(ACT_LEN + FP_LEN);
    localparam logic [CW-1:0] BP_START   = CW'(ACT_LEN + FP_LEN + SYNC_LEN);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        wrap_o   = step_i && (cnt_q == LAST);
        region_o = BP;
        if (step_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        if (cnt_q < FP_START) begin
            region_o = ACTIVE;
        end else if (cnt_q < SYNC_START) begin
            region_o = FP;
        end else if (cnt_q < BP_START) begin
            region_o = SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan engine: timing counters, incremental frame-buffer addressing and pin pipeline.
// Optional macro VGA_TEST_PATTERN_EN replaces frame-buffer colour with 8 vertical bars.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA640X480_H.active,
    parameter int H_FP        = VGA640X480_H.fp,
    parameter int H_SYNC      = VGA640X480_H.sync,
    parameter int H_BP        = VGA640X480_H.bp,
    parameter int V_ACTIVE    = VGA640X480_V.active,
    parameter int V_FP        = VGA640X480_V.fp,
    parameter int V_SYNC      = VGA640X480_V.sync,
    parameter int V_BP        = VGA640X480_V.bp,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 0,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 17,
    parameter int RGB_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_scan_engine_if.master  fb,
    output logic [RGB_W-1:0]   vga_rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int SCALE   = 1 << SCALE_SHIFT;
    localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam int DLY     = RD_LAT + 2;

    localparam logic [SW-1:0]     SUB_LAST  = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W);
    localparam pin_ctrl_t         CTRL_IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0};

    if (RD_LAT < 1) begin : g_bad_lat
        $error("vga_scan_engine: RD_LAT must be >= 1");
    end
    if (((longint'(H_ACTIVE) * V_ACTIVE) >> (2 * SCALE_SHIFT)) > (longint'(1) << ADDR_W)) begin : g_bad_aw
        $error("vga_scan_engine: frame buffer does not fit in ADDR_W");
    end
    if (((H_ACTIVE % SCALE) != 0) || ((V_ACTIVE % SCALE) != 0)) begin : g_bad_scale
        $error("vga_scan_engine: active size not divisible by 2^SCALE_SHIFT");
    end

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_wrap, v_wrap;
    region_e        h_region, v_region;

    vga_axis_counter #(.ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)) u_h (
        .clk(clk), .rst_n(rst_n), .step_i(1'b1),
        .cnt_o(h_cnt), .wrap_o(h_wrap), .region_o(h_region)
    );

    vga_axis_counter #(.ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)) u_v (
        .clk(clk), .rst_n(rst_n), .step_i(h_wrap),
        .cnt_o(v_cnt), .wrap_o(v_wrap), .region_o(v_region)
    );

    logic v_active, pix_active;
    assign v_active   = (v_region == ACTIVE);
    assign pix_active = (h_region == ACTIVE) && v_active;

    logic [SW-1:0]     sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d;

    // Address of the pixel under the counters; h wrap always falls in back porch,
    // so the line-restart branch never collides with an active-pixel advance.
    always_comb begin
        sub_x_d    = sub_x_q;
        sub_y_d    = sub_y_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        if (pix_active) begin
            if (sub_x_q == SUB_LAST) begin
                sub_x_d = '0;
                addr_d  = addr_q + ADDR_W'(1);
            end else begin
                sub_x_d = sub_x_q + SW'(1);
            end
        end
        if (h_wrap) begin
            sub_x_d = '0;
            addr_d  = row_base_q;
            if (v_wrap) begin
                sub_y_d    = '0;
                row_base_d = '0;
                addr_d     = '0;
            end else if (v_active) begin
                if (sub_y_q == SUB_LAST) begin
                    sub_y_d    = '0;
                    row_base_d = row_base_q + ROW_STEP;
                    addr_d     = row_base_q + ROW_STEP;
                end else begin
                    sub_y_d = sub_y_q + SW'(1);
                end
            end
        end
    end

    logic              fb_rd_q;
    logic [ADDR_W-1:0] fb_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x_q    <= '0;
            sub_y_q    <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            fb_rd_q    <= 1'b0;
            fb_addr_q  <= '0;
        end else begin
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
`ifdef VGA_TEST_PATTERN_EN
            fb_rd_q    <= 1'b0;
`else
            fb_rd_q    <= pix_active;
            if (pix_active) begin
                fb_addr_q <= addr_q;
            end
`endif
        end
    end

    assign fb.fb_rd   = fb_rd_q;
    assign fb.fb_addr = fb_addr_q;

    pin_ctrl_t ctrl_in;
    pin_ctrl_t ctrl_q [DLY];

    assign ctrl_in = '{de: pix_active,
                       hs: (h_region == SYNC) ? HS_POL : ~HS_POL,
                       vs: (v_region == SYNC) ? VS_POL : ~VS_POL,
                       fs: pix_active && (h_cnt == '0) && (v_cnt == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) ctrl_q[i] <= CTRL_IDLE;
        end else begin
            ctrl_q[0] <= ctrl_in;
            for (int i = 1; i < DLY; i++) ctrl_q[i] <= ctrl_q[i-1];
        end
    end

    logic [RGB_W-1:0] rgb_src;
    logic [RGB_W-1:0] rgb_q;

`ifdef VGA_TEST_PATTERN_EN
    // Bar colour follows the same stages as the memory path so latency is identical.
    logic [RGB_W-1:0] pat_q [RD_LAT+1];
    logic             unused_fb_data;
    assign unused_fb_data = ^fb.fb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) pat_q[i] <= '0;
        end else begin
            pat_q[0] <= RGB_W'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
            for (int i = 1; i <= RD_LAT; i++) pat_q[i] <= pat_q[i-1];
        end
    end
    assign rgb_src = pat_q[RD_LAT];
`else
    assign rgb_src = fb.fb_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= ctrl_q[RD_LAT].de ? rgb_src : '0;
        end
    end

    assign vga_rgb     = rgb_q;
    assign de          = ctrl_q[DLY-1].de;
    assign hsync       = ctrl_q[DLY-1].hs;
    assign vsync       = ctrl_q[DLY-1].vs;
    assign frame_start = ctrl_q[DLY-1].fs;
endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine in a 14x7 mode (8x4 active) with an fb_data = fb_addr memory.
// Three instances: SCALE_SHIFT=0/RD_LAT=1, SCALE_SHIFT=1/RD_LAT=1, SCALE_SHIFT=0/RD_LAT=3.
module tb_vga_scan_engine;
    localparam int AW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vga_scan_engine_if #(.ADDR_W(AW), .RGB_W(CW)) fb0 ();
    vga_scan_engine_if #(.ADDR_W(AW), .RGB_W(CW)) fb1 ();
    vga_scan_engine_if #(.ADDR_W(AW), .RGB_W(CW)) fb3 ();

    logic [CW-1:0] rgb0, rgb1, rgb3;
    logic hs0, vs0, de0, fs0, hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;

    vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(0), .RD_LAT(1), .ADDR_W(AW), .RGB_W(CW)) u_s0 (
        .clk(clk), .rst_n(rst_n), .fb(fb0), .vga_rgb(rgb0), .hsync(hs0), .vsync(vs0), .de(de0), .frame_start(fs0));

    vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(1), .RD_LAT(1), .ADDR_W(AW), .RGB_W(CW)) u_s1 (
        .clk(clk), .rst_n(rst_n), .fb(fb1), .vga_rgb(rgb1), .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1));

    vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(0), .RD_LAT(3), .ADDR_W(AW), .RGB_W(CW)) u_l3 (
        .clk(clk), .rst_n(rst_n), .fb(fb3), .vga_rgb(rgb3), .hsync(hs3), .vsync(vs3), .de(de3), .frame_start(fs3));

    // Memory models: data equals the address, returned RD_LAT clocks after the strobe.
    logic [AW-1:0] l3_a, l3_b;
    always @(posedge clk) begin
        fb0.fb_data <= fb0.fb_addr;
        fb1.fb_data <= fb1.fb_addr;
        l3_a        <= fb3.fb_addr;
        l3_b        <= l3_a;
        fb3.fb_data <= l3_b;
    end

    // Reference scan model indexed by t = clocks since reset release.
    function automatic int m_h(int t); return t % 14; endfunction
    function automatic int m_v(int t); return (t / 14) % 7; endfunction
    function automatic bit m_act(int t); return (t >= 0) && (m_h(t) < 8) && (m_v(t) < 4); endfunction
    function automatic bit m_hs(int t); return !((t >= 0) && (m_h(t) >= 10) && (m_h(t) < 12)); endfunction
    function automatic bit m_vs(int t); return !((t >= 0) && (m_v(t) == 5)); endfunction
    function automatic bit m_fs(int t); return (t >= 0) && ((t % 98) == 0); endfunction
    function automatic logic [7:0] m_addr0(int t); return 8'(m_v(t) * 8 + m_h(t)); endfunction
    function automatic logic [7:0] m_addr1(int t); return 8'((m_v(t) / 2) * 4 + m_h(t) / 2); endfunction

    task automatic start_scan();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 9;
        if (de0 !== 1'b0) begin errors++; $display("FAIL reset_de got %0b want 0", de0); end
        if (rgb0 !== 8'd0) begin errors++; $display("FAIL reset_rgb got %0d want 0", rgb0); end
        if (fs0 !== 1'b0) begin errors++; $display("FAIL reset_fs got %0b want 0", fs0); end
        if (hs0 !== 1'b1) begin errors++; $display("FAIL reset_hsync got %0b want 1", hs0); end
        if (vs0 !== 1'b1) begin errors++; $display("FAIL reset_vsync got %0b want 1", vs0); end
        if (fb0.fb_rd !== 1'b0) begin errors++; $display("FAIL reset_fb_rd got %0b want 0", fb0.fb_rd); end
        if (fb0.fb_addr !== 8'd0) begin errors++; $display("FAIL reset_fb_addr got %0d want 0", fb0.fb_addr); end
        if (de3 !== 1'b0) begin errors++; $display("FAIL reset_de_lat3 got %0b want 0", de3); end
        if (hs3 !== 1'b1) begin errors++; $display("FAIL reset_hsync_lat3 got %0b want 1", hs3); end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_timing();
        int first_de = -1, de_run = 0, first_hs = -1, hs_run = 0, first_vs = -1, vs_run = 0;
        int fs_cnt = 0, fs_prev = -1, fs_gap = 0;
        bit de_done = 0, hs_done = 0, vs_done = 0;
        start_scan();
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            checks += 4;
            if (de0 !== m_act(k-3)) begin errors++; $display("FAIL timing_de k=%0d got %0b want %0b", k, de0, m_act(k-3)); end
            if (hs0 !== m_hs(k-3)) begin errors++; $display("FAIL timing_hsync k=%0d got %0b want %0b", k, hs0, m_hs(k-3)); end
            if (vs0 !== m_vs(k-3)) begin errors++; $display("FAIL timing_vsync k=%0d got %0b want %0b", k, vs0, m_vs(k-3)); end
            if (fs0 !== m_fs(k-3)) begin errors++; $display("FAIL timing_fs k=%0d got %0b want %0b", k, fs0, m_fs(k-3)); end
            if (de0 === 1'b1 && first_de < 0) first_de = k;
            if (first_de >= 0 && !de_done) begin if (de0 === 1'b1) de_run++; else de_done = 1; end
            if (hs0 === 1'b0 && first_hs < 0) first_hs = k;
            if (first_hs >= 0 && !hs_done) begin if (hs0 === 1'b0) hs_run++; else hs_done = 1; end
            if (vs0 === 1'b0 && first_vs < 0) first_vs = k;
            if (first_vs >= 0 && !vs_done) begin if (vs0 === 1'b0) vs_run++; else vs_done = 1; end
            if (fs0 === 1'b1) begin
                fs_cnt++;
                if (fs_prev >= 0) fs_gap = k - fs_prev;
                fs_prev = k;
            end
        end
        checks += 8;
        if (first_de != 3) begin errors++; $display("FAIL first_de got %0d want 3", first_de); end
        if (de_run != 8) begin errors++; $display("FAIL de_run got %0d want 8", de_run); end
        if (first_hs != 13) begin errors++; $display("FAIL first_hsync got %0d want 13", first_hs); end
        if (hs_run != 2) begin errors++; $display("FAIL hsync_run got %0d want 2", hs_run); end
        if (first_vs != 73) begin errors++; $display("FAIL first_vsync got %0d want 73", first_vs); end
        if (vs_run != 14) begin errors++; $display("FAIL vsync_run got %0d want 14", vs_run); end
        if (fs_cnt != 3) begin errors++; $display("FAIL fs_count got %0d want 3", fs_cnt); end
        if (fs_gap != 98) begin errors++; $display("FAIL fs_gap got %0d want 98", fs_gap); end
        $display("test_timing: 200 clocks, errors so far %0d", errors);
    endtask

    task automatic test_addr_scale0();
        logic [7:0] held = 8'd0;
        start_scan();
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (m_act(k-1)) held = m_addr0(k-1);
            checks += 2;
            if (fb0.fb_rd !== m_act(k-1)) begin errors++; $display("FAIL s0_fb_rd k=%0d got %0b want %0b", k, fb0.fb_rd, m_act(k-1)); end
            if (fb0.fb_addr !== held) begin errors++; $display("FAIL s0_fb_addr k=%0d got %0d want %0d", k, fb0.fb_addr, held); end
            if (k == 43 || k == 99) begin
                checks++;
                if (fb0.fb_addr !== ((k == 43) ? 8'd24 : 8'd0)) begin
                    errors++; $display("FAIL s0_line_start k=%0d got %0d want %0d", k, fb0.fb_addr, (k == 43) ? 24 : 0);
                end
            end
        end
        $display("test_addr_scale0: 200 clocks, errors so far %0d", errors);
    endtask

    task automatic test_addr_scale1();
        logic [7:0] held = 8'd0;
        start_scan();
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge clk);
            if (m_act(k-1)) held = m_addr1(k-1);
            checks += 2;
            if (fb1.fb_rd !== m_act(k-1)) begin errors++; $display("FAIL s1_fb_rd k=%0d got %0b want %0b", k, fb1.fb_rd, m_act(k-1)); end
            if (fb1.fb_addr !== held) begin errors++; $display("FAIL s1_fb_addr k=%0d got %0d want %0d", k, fb1.fb_addr, held); end
        end
        $display("test_addr_scale1: 120 clocks, errors so far %0d", errors);
    endtask

    task automatic test_alignment();
        logic [7:0] exp0, exp1, exp3;
        start_scan();
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            exp0 = m_act(k-3) ? m_addr0(k-3) : 8'd0;
            exp1 = m_act(k-3) ? m_addr1(k-3) : 8'd0;
            exp3 = m_act(k-5) ? m_addr0(k-5) : 8'd0;
            checks += 6;
            if (rgb0 !== exp0) begin errors++; $display("FAIL align_rgb_lat1 k=%0d got %0d want %0d", k, rgb0, exp0); end
            if (rgb1 !== exp1) begin errors++; $display("FAIL align_rgb_scale1 k=%0d got %0d want %0d", k, rgb1, exp1); end
            if (rgb3 !== exp3) begin errors++; $display("FAIL align_rgb_lat3 k=%0d got %0d want %0d", k, rgb3, exp3); end
            if (de3 !== m_act(k-5)) begin errors++; $display("FAIL align_de_lat3 k=%0d got %0b want %0b", k, de3, m_act(k-5)); end
            if (hs3 !== m_hs(k-5)) begin errors++; $display("FAIL align_hsync_lat3 k=%0d got %0b want %0b", k, hs3, m_hs(k-5)); end
            if (vs3 !== m_vs(k-5)) begin errors++; $display("FAIL align_vsync_lat3 k=%0d got %0b want %0b", k, vs3, m_vs(k-5)); end
        end
        $display("test_alignment: 200 clocks, errors so far %0d", errors);
    endtask

    task automatic test_mid_reset();
        start_scan();
        for (int k = 1; k <= 33; k++) @(negedge clk);
        checks += 2;
        if (de0 !== 1'b1) begin errors++; $display("FAIL midrst_pre_de got %0b want 1", de0); end
        if (fb0.fb_rd !== 1'b1) begin errors++; $display("FAIL midrst_pre_fb_rd got %0b want 1", fb0.fb_rd); end
        #1 rst_n = 1'b0;
        #1;
        checks += 8;
        if (de0 !== 1'b0) begin errors++; $display("FAIL midrst_de got %0b want 0", de0); end
        if (rgb0 !== 8'd0) begin errors++; $display("FAIL midrst_rgb got %0d want 0", rgb0); end
        if (hs0 !== 1'b1) begin errors++; $display("FAIL midrst_hsync got %0b want 1", hs0); end
        if (vs0 !== 1'b1) begin errors++; $display("FAIL midrst_vsync got %0b want 1", vs0); end
        if (fs0 !== 1'b0) begin errors++; $display("FAIL midrst_fs got %0b want 0", fs0); end
        if (fb0.fb_rd !== 1'b0) begin errors++; $display("FAIL midrst_fb_rd got %0b want 0", fb0.fb_rd); end
        if (fb0.fb_addr !== 8'd0) begin errors++; $display("FAIL midrst_fb_addr got %0d want 0", fb0.fb_addr); end
        if (de3 !== 1'b0) begin errors++; $display("FAIL midrst_de_lat3 got %0b want 0", de3); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 110; k++) begin
            if (k > 0) @(negedge clk);
            checks += 4;
            if (de0 !== m_act(k-3)) begin errors++; $display("FAIL rerun_de k=%0d got %0b want %0b", k, de0, m_act(k-3)); end
            if (hs0 !== m_hs(k-3)) begin errors++; $display("FAIL rerun_hsync k=%0d got %0b want %0b", k, hs0, m_hs(k-3)); end
            if (vs0 !== m_vs(k-3)) begin errors++; $display("FAIL rerun_vsync k=%0d got %0b want %0b", k, vs0, m_vs(k-3)); end
            if (fs0 !== m_fs(k-3)) begin errors++; $display("FAIL rerun_fs k=%0d got %0b want %0b", k, fs0, m_fs(k-3)); end
        end
        $display("test_mid_reset: 110 clocks after release, errors so far %0d", errors);
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [7:0] exp;
        start_scan();
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge clk);
            exp = m_act(k-3) ? 8'(m_h(k-3)) : 8'd0;
            checks += 2;
            if (fb0.fb_rd !== 1'b0) begin errors++; $display("FAIL pattern_fb_rd k=%0d got %0b want 0", k, fb0.fb_rd); end
            if (rgb0 !== exp) begin errors++; $display("FAIL pattern_rgb k=%0d got %0d want %0d", k, rgb0, exp); end
        end
        $display("test_pattern: 120 clocks, errors so far %0d", errors);
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`else
        test_addr_scale0();
        test_addr_scale1();
        test_alignment();
`endif
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
